mem_sort_ctrl: RTL and testbench

- Sequencer that owns the 32x8 data memory's rd/wr/adr/WriteData ports and sorts its contents in place, ascending unsigned, using bubble sort.
- Sits between the top-level control (start/done handshake) and the memory instance; the memory has a clocked write and an asynchronous read.
- Exposes swap and compare counters for verification and debug.

---
 rtl/mem_sort_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mem_sort_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sort_ctrl.sv
// mem_sort_ctrl: in-place ascending (unsigned) bubble sort of a DEPTH x DW memory.
//
// The block owns the memory's rd/wr/adr/WriteData ports. The memory writes on the
// rising clk edge and reads combinationally from rd/adr.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a sort; sampled only while idle
//   busy       high from the cycle after start is accepted through the done cycle
//   done       one-cycle completion pulse
//   rd, wr     memory read / write enables (never both high)
//   adr        memory address
//   WriteData  memory write data
//   ReadData   memory read data
//   swap_cnt   swaps in the current/last sort, saturating
//   cmp_cnt    compares in the current/last sort, saturating
//
// Optional feature: define MEM_SORT_EARLY_EXIT_EN to finish as soon as a full
// pass completes without any swap.
module mem_sort_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] ReadData,
  output logic [15:0]   swap_cnt,
  output logic [15:0]   cmp_cnt
);

  // Highest pass index; also the element-index limit of the first pass.
  localparam logic [AW:0] LastIdx = (AW+1)'(DEPTH - 2);

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCmp,
    StWrA,
    StWrB,
    StDone
  } state_e;

  state_e        state_q;
  logic [AW-1:0] i_q;
  logic [AW-1:0] j_q;
  logic [DW-1:0] reg_a_q;
  logic [DW-1:0] reg_b_q;
`ifdef MEM_SORT_EARLY_EXIT_EN
  logic          pass_swap_q;
  logic          adv_new_pass;
`endif

  logic          more_j;
  logic          more_i;
  logic          pass_end_done;
  logic [AW-1:0] j_inc;
  logic [AW-1:0] adv_i;
  logic [AW-1:0] adv_j;
  logic          adv_done;

  // Index advance after a compare (no swap) or after the second swap write.
  always_comb begin
    j_inc  = j_q + AW'(1);
    more_j = ({1'b0, j_q} < (LastIdx - {1'b0, i_q}));
    more_i = ({1'b0, i_q} < LastIdx);
`ifdef MEM_SORT_EARLY_EXIT_EN
    // A pass with no swap proves the array is already ordered.
    pass_end_done = !more_j && (!more_i || !pass_swap_q);
    adv_new_pass  = 1'b0;
`else
    pass_end_done = !more_j && !more_i;
`endif
    adv_i    = i_q;
    adv_j    = j_q;
    adv_done = 1'b0;
    if (more_j) begin
      adv_j = j_inc;
    end else if (pass_end_done) begin
      adv_done = 1'b1;
    end else begin
      adv_i = i_q + AW'(1);
      adv_j = '0;
`ifdef MEM_SORT_EARLY_EXIT_EN
      adv_new_pass = 1'b1;
`endif
    end
  end

  // Outputs are registered: each transition loads the values the next state drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      adr         <= '0;
      WriteData   <= '0;
      swap_cnt    <= '0;
      cmp_cnt     <= '0;
`ifdef MEM_SORT_EARLY_EXIT_EN
      pass_swap_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StRdA;
            i_q         <= '0;
            j_q         <= '0;
            swap_cnt    <= '0;
            cmp_cnt     <= '0;
            busy        <= 1'b1;
            rd          <= 1'b1;
            adr         <= '0;
`ifdef MEM_SORT_EARLY_EXIT_EN
            pass_swap_q <= 1'b0;
`endif
          end
        end
        StRdA: begin
          reg_a_q <= ReadData;
          adr     <= j_inc;
          state_q <= StRdB;
        end
        StRdB: begin
          reg_b_q <= ReadData;
          rd      <= 1'b0;
          state_q <= StCmp;
        end
        StCmp: begin
          if (cmp_cnt != 16'hFFFF) cmp_cnt <= cmp_cnt + 16'd1;
          if (reg_a_q > reg_b_q) begin
            if (swap_cnt != 16'hFFFF) swap_cnt <= swap_cnt + 16'd1;
`ifdef MEM_SORT_EARLY_EXIT_EN
            pass_swap_q <= 1'b1;
`endif
            wr        <= 1'b1;
            adr       <= j_q;
            WriteData <= reg_b_q;
            state_q   <= StWrA;
          end else begin
            i_q <= adv_i;
            j_q <= adv_j;
`ifdef MEM_SORT_EARLY_EXIT_EN
            if (adv_new_pass) pass_swap_q <= 1'b0;
`endif
            if (adv_done) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              rd      <= 1'b1;
              adr     <= adv_j;
              state_q <= StRdA;
            end
          end
        end
        StWrA: begin
          adr       <= j_inc;
          WriteData <= reg_a_q;
          state_q   <= StWrB;
        end
        StWrB: begin
          wr  <= 1'b0;
          i_q <= adv_i;
          j_q <= adv_j;
`ifdef MEM_SORT_EARLY_EXIT_EN
          if (adv_new_pass) pass_swap_q <= 1'b0;
`endif
          if (adv_done) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            rd      <= 1'b1;
            adr     <= adv_j;
            state_q <= StRdA;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          rd      <= 1'b0;
          wr      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sort_ctrl.sv
module tb_mem_sort_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

`ifdef MEM_SORT_EARLY_EXIT_EN
  localparam int SORTED_CMP = 31;
  localparam int SORTED_CYC = 94;
`else
  localparam int SORTED_CMP = 496;
  localparam int SORTED_CYC = 1489;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd, wr;
  logic [AW-1:0] adr;
  logic [DW-1:0] WriteData, ReadData;
  logic [15:0]   swap_cnt, cmp_cnt;

  mem_sort_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd        (rd),
    .wr        (wr),
    .adr       (adr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .swap_cnt  (swap_cnt),
    .cmp_cnt   (cmp_cnt)
  );

  always #5 clk = ~clk;

  // Memory: clocked write, asynchronous read; bench preloads through load_req.
  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] init_mem [DEPTH];
  logic [DW-1:0] exp_mem  [DEPTH];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) mem <= init_mem;
    else if (wr) mem[adr] <= WriteData;
  end
  assign ReadData = rd ? mem[adr] : '0;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int m_cmp, m_swp, m_cyc, last_cyc;
  bit prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one cycle and check the per-cycle output rules.
  task automatic tick();
    @(negedge clk);
    total++;
    if ((rd && wr) || (done && !busy) || (!busy && (rd || wr)) || (done && prev_done)) begin
      bad++;
      $display("FAIL cycle_rules t=%0t rd=%b wr=%b busy=%b done=%b prev_done=%b",
               $time, rd, wr, busy, done, prev_done);
    end
    prev_done = done;
    if (wr) wr_seen++;
  endtask

  task automatic load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Expected result: sorted array, compares from bubble passes, swaps = inversion count.
  task automatic compute_model();
    logic [DW-1:0] a [DEPTH];
    logic [DW-1:0] t;
    bit sw;
    for (int k = 0; k < DEPTH; k++) a[k] = init_mem[k];
    m_swp = 0;
    for (int p = 0; p < DEPTH; p++)
      for (int q = p + 1; q < DEPTH; q++)
        if (init_mem[p] > init_mem[q]) m_swp++;
    m_cmp = 0;
    for (int p = 0; p < DEPTH - 1; p++) begin
      sw = 1'b0;
      for (int q = 0; q < DEPTH - 1 - p; q++) begin
        m_cmp++;
        if (a[q] > a[q+1]) begin
          t = a[q]; a[q] = a[q+1]; a[q+1] = t; sw = 1'b1;
        end
      end
`ifdef MEM_SORT_EARLY_EXIT_EN
      if (!sw) break;
`endif
    end
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = a[k];
    m_cyc = 3 * m_cmp + 2 * m_swp + 1;
  endtask

  // From the current sample point, count busy cycles up to and including done.
  task automatic wait_done(input string name, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 6000; k++) begin
      if (busy) cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_result(input string name, input int cyc);
    int nerr;
    nerr = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== exp_mem[k]) nerr++;
    check({name, "_mem"}, 32'(nerr), 32'd0);
    check({name, "_cmp"}, 32'(cmp_cnt), 32'(m_cmp));
    check({name, "_swap"}, 32'(swap_cnt), 32'(m_swp));
    check({name, "_cycles"}, 32'(cyc), 32'(m_cyc));
  endtask

  task automatic run_sort(input string name, input bit mid_start);
    int cyc, pre;
    load();
    compute_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    pre = 0;
    if (mid_start) begin
      for (int k = 0; k < 50; k++) begin
        if (busy) pre++;
        tick();
      end
      start = 1'b1;
      if (busy) pre++;
      tick();
      start = 1'b0;
    end
    wait_done(name, cyc);
    cyc += pre;
    last_cyc = cyc;
    tick();
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check_result(name, cyc);
    tick();
    check({name, "_cmp_hold"}, 32'(cmp_cnt), 32'(m_cmp));
  endtask

  initial begin
    int w0, cyc, nwrb;
    bit found;
    bit pw;

    // Reset state, checked while reset is held and after release.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_rd_wr", {29'd0, done, rd, wr}, 32'd0);
    check("rst_adr_wdata", {19'd0, adr, WriteData}, 32'd0);
    check("rst_counters", {swap_cnt, cmp_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Already ascending: no writes at all.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'(k);
    w0 = wr_seen;
    run_sort("asc", 1'b0);
    check("asc_no_wr", 32'(wr_seen - w0), 32'd0);
    check("asc_cmp_lit", 32'(cmp_cnt), 32'(SORTED_CMP));
    check("asc_cyc_lit", 32'(last_cyc), 32'(SORTED_CYC));

    // Descending: every compare swaps.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'(DEPTH - 1 - k);
    run_sort("desc", 1'b0);
    check("desc_swap_lit", 32'(swap_cnt), 32'd496);
    check("desc_cmp_lit", 32'(cmp_cnt), 32'd496);
    check("desc_cyc_lit", 32'(last_cyc), 32'd2481);
    check("desc_mem_lit", {mem[0], mem[5], mem[17], mem[31]}, {8'd0, 8'd5, 8'd17, 8'd31});

    // All equal: never swapped.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = 8'hA5;
    run_sort("same", 1'b0);
    check("same_swap_lit", 32'(swap_cnt), 32'd0);
    check("same_cmp_lit", 32'(cmp_cnt), 32'(SORTED_CMP));

    // Mixed values with extremes and duplicates; start pulsed mid-sort.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'((k * 37 + 11) & 255);
    init_mem[3] = 8'h00; init_mem[20] = 8'hFF; init_mem[7] = 8'h42; init_mem[8] = 8'h42;
    init_mem[29] = 8'hFF; init_mem[12] = 8'h00;
    run_sort("mixed", 1'b1);
    check("mixed_ends_lit", {mem[0], mem[1], mem[30], mem[31]}, {8'h00, 8'h00, 8'hFF, 8'hFF});

    // Reset asserted during the WR_B cycle of the third swap.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'(DEPTH - 1 - k);
    load();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    pw = 1'b0;
    nwrb = 0;
    for (int k = 0; k < 200; k++) begin
      if (wr && pw) begin
        nwrb++;
        if (nwrb == 3) begin
          found = 1'b1;
          break;
        end
      end
      pw = wr;
      tick();
    end
    check("rst_find_wrb", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {28'd0, busy, rd, wr, done}, 32'd0);
    check("rst_mid_counters", {swap_cnt, cmp_cnt}, 32'd0);
    check("rst_mid_dup", {16'd0, mem[2], mem[3]}, {16'd0, 8'd28, 8'd28});
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_rel_idle", {30'd0, busy, done}, 32'd0);
    for (int k = 0; k < DEPTH; k++) init_mem[k] = mem[k];
    run_sort("after_rst", 1'b0);

    // Back-to-back: start held high through two sorts.
    for (int k = 0; k < DEPTH; k++) init_mem[k] = DW'((k * 91 + 5) & 255);
    load();
    compute_model();
    start = 1'b1;
    tick();
    wait_done("b2b1", cyc);
    check_result("b2b1", cyc);
    tick();
    check("b2b_gap_busy", 32'(busy), 32'd0);
    check("b2b_gap_swap_hold", 32'(swap_cnt), 32'(m_swp));
    tick();
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_cnt", {swap_cnt, cmp_cnt}, 32'd0);
    start = 1'b0;
    for (int k = 0; k < DEPTH; k++) init_mem[k] = exp_mem[k];
    compute_model();
    wait_done("b2b2", cyc);
    check_result("b2b2", cyc);
    check("b2b2_cyc_lit", 32'(cyc), 32'(SORTED_CYC));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
